// File: rtl/descrambler_pkg.sv
// Shared definitions for the x^7+x^4+1 additive scrambler family:
// polynomial taps, sequence-state width, descrambler FSM states and the
// per-bit recurrence used by the sequence generator.
package descrambler_pkg;

  // Width of the sequence state (degree of the polynomial).
  localparam int SEQ_W  = 7;

  // Polynomial taps: b[n] = b[n-TAP_HI] xor b[n-TAP_LO].
  localparam int TAP_HI = 7;
  localparam int TAP_LO = 4;

  // SEED: waiting for the first beat of a frame; RUN: mid-frame.
  typedef enum logic {
    FSM_SEED = 1'b0,
    FSM_RUN  = 1'b1
  } fsm_e;

  // One step of the sequence recurrence.
  function automatic logic seq_next_bit(input logic i_b_hi, input logic i_b_lo);
    return i_b_hi ^ i_b_lo;
  endfunction

endpackage

// File: rtl/scrambler_seq.sv
// Combinational sequence generator for the x^7+x^4+1 additive scrambler.
// Given the last seven sequence bits (bit 0 oldest), produces the next WIDTH
// sequence bits (bit 0 earliest) and the state after them, i.e. the final
// seven generated bits. Shared by the scrambler and the descrambler.
module scrambler_seq
  import descrambler_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic [SEQ_W-1:0] i_state,
  output logic [WIDTH-1:0] o_seq,
  output logic [SEQ_W-1:0] o_next_state
);

  // Full history: state bits followed by all generated bits.
  logic [WIDTH+SEQ_W-1:0] w_ext;

  // Unrolled recurrence over the whole beat.
  function automatic logic [WIDTH+SEQ_W-1:0] expand(input logic [SEQ_W-1:0] i_s);
    logic [WIDTH+SEQ_W-1:0] v_e;
    v_e             = '0;
    v_e[SEQ_W-1:0]  = i_s;
    for (int n = SEQ_W; n < WIDTH + SEQ_W; n++) begin
      v_e[n] = seq_next_bit(v_e[n-TAP_HI], v_e[n-TAP_LO]);
    end
    return v_e;
  endfunction

  assign w_ext        = expand(i_state);
  assign o_seq        = w_ext[WIDTH+SEQ_W-1:SEQ_W];
  assign o_next_state = w_ext[WIDTH+SEQ_W-1:WIDTH];

endmodule

// File: rtl/descrambler.sv
// Self-synchronising-seed descrambler for the additive x^7+x^4+1 scrambler.
// The first seven bits of each frame are taken as the sequence seed (their
// descrambled value is forced to zero); the rest of the frame is XORed with
// the regenerated sequence. One-cycle registered AXI-Stream pipeline with
// full throughput and skid-free backpressure (tready = !tvalid || m_tready).
module descrambler
  import descrambler_pkg::*;
#(
  parameter int WIDTH      = 24,
  parameter int USER_WIDTH = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [WIDTH-1:0]      s_axis_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [WIDTH-1:0]      m_axis_tdata,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [SEQ_W-1:0]      seed,
  output logic                  seed_valid
);

  fsm_e                  r_fsm;
  fsm_e                  w_fsm_nxt;
  logic [SEQ_W-1:0]      r_state;
  logic [SEQ_W-1:0]      w_state_nxt;
  logic [SEQ_W-1:0]      w_gen_in;
  logic [SEQ_W-1:0]      w_gen_next;
  logic [WIDTH-1:0]      w_gen_seq;
  logic [WIDTH-1:0]      w_seq;
  logic [WIDTH-1:0]      w_dout;
  logic                  w_accept;

  logic [WIDTH-1:0]      r_tdata;
  logic [USER_WIDTH-1:0] r_tuser;
  logic                  r_tlast;
  logic                  r_tvalid;
  logic [SEQ_W-1:0]      r_seed;
  logic                  r_seed_valid;

  assign s_axis_tready = !r_tvalid || m_axis_tready;
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  // At a frame start the incoming seven bits are the seed themselves, so the
  // generator is driven from the data instead of the stored state.
  assign w_gen_in = (r_fsm == FSM_SEED) ? s_axis_tdata[SEQ_W-1:0] : r_state;

  scrambler_seq #(
    .WIDTH (WIDTH)
  ) u_seq (
    .i_state      (w_gen_in),
    .o_seq        (w_gen_seq),
    .o_next_state (w_gen_next)
  );

  // Next FSM/state and the descrambled beat for the current input.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_state_nxt = r_state;
    w_seq       = w_gen_seq;
    w_dout      = s_axis_tdata ^ w_gen_seq;
    if (r_fsm == FSM_SEED) begin
      // Sequence bits 0..6 are the seed, generated bits follow from bit 7.
      w_seq                = {w_gen_seq[WIDTH-SEQ_W-1:0], s_axis_tdata[SEQ_W-1:0]};
      w_dout               = s_axis_tdata ^ w_seq;
      w_dout[SEQ_W-1:0]    = '0;
    end
    if (w_accept) begin
      // Keep the last seven sequence bits so the period continues across beats.
      w_state_nxt = (r_fsm == FSM_SEED) ? w_seq[WIDTH-1 -: SEQ_W] : w_gen_next;
      w_fsm_nxt   = s_axis_tlast ? FSM_SEED : FSM_RUN;
    end
  end

  // FSM and sequence state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_fsm   <= FSM_SEED;
      r_state <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Output beat register; only loads when the downstream slot is free.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tuser  <= '0;
      r_tlast  <= 1'b0;
    end else if (s_axis_tready) begin
      r_tvalid <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        r_tdata <= w_dout;
        r_tuser <= s_axis_tuser;
        r_tlast <= s_axis_tlast;
      end
    end
  end

  // Seed capture at frame start; validity drops once the frame's last beat is taken.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_seed       <= '0;
      r_seed_valid <= 1'b0;
    end else if (w_accept) begin
      if (r_fsm == FSM_SEED) begin
        r_seed       <= s_axis_tdata[SEQ_W-1:0];
        r_seed_valid <= 1'b1;
      end
      if (s_axis_tlast) begin
        r_seed_valid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;
  assign seed          = r_seed;
  assign seed_valid    = r_seed_valid;

endmodule

// File: tb/tb_descrambler.sv
// Randomised self-checking bench for the descrambler. Stimulus comes from a
// bench-side frame scrambler; expectations come from a frame-level model that
// keeps the whole received sequence history and applies the recurrence by index.
module tb_descrambler;

  localparam int W  = 24;
  localparam int UW = 4;

  logic          aclk;
  logic          aresetn;
  logic [W-1:0]  s_axis_tdata;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [W-1:0]  m_axis_tdata;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [6:0]    seed;
  logic          seed_valid;

  descrambler #(.WIDTH(W), .USER_WIDTH(UW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .seed          (seed),
    .seed_valid    (seed_valid)
  );

  typedef struct packed {
    logic [W-1:0]  data;
    logic [UW-1:0] user;
    logic          last;
    logic [6:0]    sd;
    logic          sd_vld;
  } exp_t;

  exp_t exp_q[$];
  bit   rx_b[$];     // model: sequence bits of the current received frame
  bit   tx_b[$];     // stimulus: sequence bits of the current transmitted frame
  logic [6:0] tx_seed;

  int n_checks = 0;
  int n_errors = 0;
  bit rand_rdy = 0;
  logic rdy_force = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Downstream ready: forced value or random toggling.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Reference model: first 7 bits of a frame are the sequence itself,
  // later bits follow b[n] = b[n-7] ^ b[n-4] over the whole frame.
  task automatic model_accept();
    exp_t e;
    int   n;
    bit   b;
    e = '0;
    for (int i = 0; i < W; i++) begin
      n = rx_b.size();
      if (n < 7) b = s_axis_tdata[i];
      else       b = rx_b[n-7] ^ rx_b[n-4];
      rx_b.push_back(b);
      e.data[i] = (n < 7) ? 1'b0 : (s_axis_tdata[i] ^ b);
    end
    for (int j = 0; j < 7; j++) e.sd[j] = rx_b[j];
    e.user   = s_axis_tuser;
    e.last   = s_axis_tlast;
    e.sd_vld = !s_axis_tlast;
    if (s_axis_tlast) rx_b.delete();
    exp_q.push_back(e);
  endtask

  // Checker on the falling edge: reset values, output beats, model update.
  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_tuser", m_axis_tuser, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_seed", seed, 0);
      chk("rst_seed_valid", seed_valid, 0);
      exp_q.delete();
      rx_b.delete();
    end else begin
      if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", m_axis_tvalid, 0);
        end else begin
          chk("tdata", m_axis_tdata, exp_q[0].data);
          chk("tuser", m_axis_tuser, exp_q[0].user);
          chk("tlast", m_axis_tlast, exp_q[0].last);
          chk("seed", seed, exp_q[0].sd);
          chk("seed_valid", seed_valid, exp_q[0].sd_vld);
          if (m_axis_tready) void'(exp_q.pop_front());
        end
      end
      if (s_axis_tvalid && s_axis_tready) model_accept();
    end
  end

  // Drive one beat (called at posedge+1); returns after it is accepted.
  task automatic drive_beat(input logic [W-1:0] d, input logic [UW-1:0] u, input logic l);
    int cyc;
    bit done;
    cyc = 0;
    done = 0;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!done) begin
      @(negedge aclk);
      if (s_axis_tready) done = 1;
      @(posedge aclk);
      #1;
      cyc++;
      if (!done && cyc > 200) begin
        chk("accept_timeout", cyc, 0);
        done = 1;
      end
    end
  endtask

  task automatic new_frame(input logic [6:0] sd);
    tx_b.delete();
    tx_seed = sd;
  endtask

  // Next scrambled beat of the bench frame; the first 7 data bits of a frame are zero.
  task automatic gen_beat(input bit zeros, output logic [W-1:0] tx);
    int n;
    bit s;
    bit d;
    for (int i = 0; i < W; i++) begin
      n = tx_b.size();
      s = (n < 7) ? tx_seed[n] : (tx_b[n-7] ^ tx_b[n-4]);
      tx_b.push_back(s);
      d = (zeros || n < 7) ? 1'b0 : 1'($urandom_range(0, 1));
      tx[i] = d ^ s;
    end
  endtask

  task automatic send_beats(input int nb, input bit zeros, input int ubase, input bit last_end);
    logic [W-1:0] tx;
    for (int k = 0; k < nb; k++) begin
      gen_beat(zeros, tx);
      drive_beat(tx, UW'(ubase + k), last_end && (k == nb - 1));
    end
  endtask

  task automatic idle_cycles(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  initial begin
    logic [W-1:0] tx;
    logic [6:0]   sd_a;
    logic [6:0]   sd_b;
    int           wait_cyc;

    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("tready_after_reset", s_axis_tready, 1);
    @(posedge aclk);
    #1;

    // Known vector: scrambled zeros, then ten more beats across the period wrap.
    new_frame(7'b1110000);
    gen_beat(1, tx);
    drive_beat(24'h934F70, 0, 0);
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    chk("vec_tvalid", m_axis_tvalid, 1);
    chk("vec_tdata", m_axis_tdata, 24'h000000);
    chk("vec_seed", seed, 7'b1110000);
    chk("vec_seed_valid", seed_valid, 1);
    @(posedge aclk);
    #1;
    send_beats(10, 1, 1, 1);
    idle_cycles(3);

    // Random payload recovered, tuser 0..9.
    new_frame(7'b1011101);
    send_beats(10, 0, 0, 1);
    idle_cycles(3);

    // Short frame, then a new frame from a different seed.
    sd_a = 7'($urandom);
    sd_b = sd_a ^ 7'h55;
    new_frame(sd_a);
    send_beats(4, 0, 3, 1);
    new_frame(sd_b);
    gen_beat(0, tx);
    drive_beat(tx, 4'hA, 0);
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    chk("reseed_seed", seed, sd_b);
    chk("reseed_seed_valid", seed_valid, 1);
    @(posedge aclk);
    #1;
    send_beats(3, 0, 11, 1);
    idle_cycles(3);

    // Continuous valid with randomly stalling downstream.
    rand_rdy = 1;
    for (int f = 0; f < 6; f++) begin
      new_frame(7'($urandom));
      send_beats($urandom_range(2, 8), 0, $urandom_range(0, 15), 1);
    end
    s_axis_tvalid = 1'b0;
    rand_rdy = 0;
    rdy_force = 1'b1;
    idle_cycles(5);

    // Reset mid-frame with a stalled beat in flight.
    new_frame(7'($urandom));
    send_beats(2, 0, 0, 0);
    rdy_force = 1'b0;
    idle_cycles(4);
    gen_beat(0, tx);
    s_axis_tdata  = tx;
    s_axis_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    idle_cycles(2);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("tready_after_reset2", s_axis_tready, 1);
    rdy_force = 1'b1;
    @(posedge aclk);
    #1;
    @(posedge aclk);
    #1;
    drive_beat(24'h934F70, 5, 0);
    s_axis_tvalid = 1'b0;
    @(negedge aclk);
    chk("post_rst_tdata", m_axis_tdata, 24'h000000);
    chk("post_rst_seed", seed, 7'b1110000);
    chk("post_rst_seed_valid", seed_valid, 1);
    @(posedge aclk);
    #1;

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 100) begin
      @(posedge aclk);
      #1;
      wait_cyc++;
    end
    chk("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
